// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing generator.
// Holds the mode enumeration, the per-axis timing record and the derived-total functions.
package video_timing_pkg;

    typedef enum logic {
        Mode0 = 1'b0,
        Mode1 = 1'b1
    } mode_e;

    typedef struct packed {
        int unsigned act;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    function automatic int unsigned axis_total(axis_timing_t t);
        return t.act + t.fp + t.sync + t.bp;
    endfunction

    function automatic int unsigned sync_start(axis_timing_t t);
        return t.act + t.fp;
    endfunction

    function automatic int unsigned sync_end(axis_timing_t t);
        return t.act + t.fp + t.sync;
    endfunction

    // True when values 0..count-1 are representable in width bits.
    function automatic bit fits(int unsigned count, int unsigned width);
        return 64'(count) <= (64'(1) << width);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-strobe / mode request inputs and registered raster outputs of the timing generator.
interface video_timing_gen_if #(
    parameter int unsigned H_W    = 10,
    parameter int unsigned V_W    = 10,
    parameter int unsigned ADDR_W = 19
);
    logic              pix_en;
    logic              mode_sel;
    logic              mode_active;
    logic              h_blank;
    logic              h_sync;
    logic              v_blank;
    logic              v_sync;
    logic              de;
    logic [H_W-1:0]    x;
    logic [V_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
    logic              line_start;
    logic              frame_start;

    modport master (
        input  pix_en, mode_sel,
        output mode_active, h_blank, h_sync, v_blank, v_sync, de, x, y, addr,
        output line_start, frame_start
    );

    modport slave (
        output pix_en, mode_sel,
        input  mode_active, h_blank, h_sync, v_blank, v_sync, de, x, y, addr,
        input  line_start, frame_start
    );
endinterface

// File: rtl/timing_axis.sv
// One raster axis: wrapping counter plus registered blank/sync decode of the next count.
// Wrap uses the mode in effect; decode uses the mode that will be in effect after the edge.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned  Width   = 10,
    parameter bit           SyncPol = 1'b1,
    parameter axis_timing_t Timing0 = '{act: 400, fp: 20, sync: 64, bp: 44},
    parameter axis_timing_t Timing1 = '{act: 640, fp: 16, sync: 96, bp: 48}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             advance_i,
    input  mode_e            mode_cur_i,
    input  mode_e            mode_nxt_i,
    output logic [Width-1:0] cnt_o,
    output logic             wrap_o,
    output logic             blank_o,
    output logic             blank_nxt_o,
    output logic             sync_o
);
    axis_timing_t     t_cur;
    axis_timing_t     t_nxt;
    logic [Width-1:0] last;
    logic [Width-1:0] cnt_q, cnt_d;
    logic [31:0]      cnt_ext;
    logic             blank_q;
    logic             sync_q, sync_d;

    // Kept as separate statements so the mode_nxt path never loops back into wrap.
    assign t_cur  = (mode_cur_i == Mode1) ? Timing1 : Timing0;
    assign last   = Width'(axis_total(t_cur) - 1);
    assign wrap_o = advance_i && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (advance_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    assign t_nxt       = (mode_nxt_i == Mode1) ? Timing1 : Timing0;
    assign cnt_ext     = 32'(cnt_d);
    assign blank_nxt_o = cnt_ext >= t_nxt.act;

    always_comb begin
        sync_d = !SyncPol;
        if (cnt_ext >= sync_start(t_nxt) && cnt_ext < sync_end(t_nxt)) begin
            sync_d = SyncPol;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            blank_q <= 1'b0;
            sync_q  <= !SyncPol;
        end else if (advance_i) begin
            cnt_q   <= cnt_d;
            blank_q <= blank_nxt_o;
            sync_q  <= sync_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign blank_o = blank_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Two-mode raster timing generator: registered blank/sync/de, pixel address and line/frame pulses.
// Mode requests are honoured only at the frame wrap so no line or frame is ever cut short.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_W        = 10,
    parameter int unsigned V_W        = 10,
    parameter int unsigned ADDR_W     = 19,
    parameter bit          H_SYNC_POL = 1'b1,
    parameter bit          V_SYNC_POL = 1'b1,
    parameter int unsigned M0_H_ACT   = 400,
    parameter int unsigned M0_H_FP    = 20,
    parameter int unsigned M0_H_SYNC  = 64,
    parameter int unsigned M0_H_BP    = 44,
    parameter int unsigned M0_V_ACT   = 600,
    parameter int unsigned M0_V_FP    = 1,
    parameter int unsigned M0_V_SYNC  = 4,
    parameter int unsigned M0_V_BP    = 23,
    parameter int unsigned M1_H_ACT   = 640,
    parameter int unsigned M1_H_FP    = 16,
    parameter int unsigned M1_H_SYNC  = 96,
    parameter int unsigned M1_H_BP    = 48,
    parameter int unsigned M1_V_ACT   = 480,
    parameter int unsigned M1_V_FP    = 10,
    parameter int unsigned M1_V_SYNC  = 2,
    parameter int unsigned M1_V_BP    = 33
) (
    input logic                clk,
    input logic                rst,
    video_timing_gen_if.master bus
);
    localparam axis_timing_t H_T0 = '{act: M0_H_ACT, fp: M0_H_FP, sync: M0_H_SYNC, bp: M0_H_BP};
    localparam axis_timing_t V_T0 = '{act: M0_V_ACT, fp: M0_V_FP, sync: M0_V_SYNC, bp: M0_V_BP};
    localparam axis_timing_t H_T1 = '{act: M1_H_ACT, fp: M1_H_FP, sync: M1_H_SYNC, bp: M1_H_BP};
    localparam axis_timing_t V_T1 = '{act: M1_V_ACT, fp: M1_V_FP, sync: M1_V_SYNC, bp: M1_V_BP};

    localparam bit CFG_OK = fits(axis_total(H_T0), H_W) && fits(axis_total(H_T1), H_W) &&
                            fits(axis_total(V_T0), V_W) && fits(axis_total(V_T1), V_W) &&
                            fits(M0_H_ACT * M0_V_ACT, ADDR_W) &&
                            fits(M1_H_ACT * M1_V_ACT, ADDR_W);

    localparam logic [ADDR_W-1:0] ADDR_LAST0 = ADDR_W'(M0_H_ACT * M0_V_ACT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST1 = ADDR_W'(M1_H_ACT * M1_V_ACT - 1);

    mode_e             mode_q, mode_d;
    logic              h_wrap, v_wrap;
    logic              h_blank_nxt, v_blank_nxt;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_last;
    logic              de_q, de_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;

    // v only advances on an h wrap, so its wrap marks the frame boundary.
    assign mode_d    = v_wrap ? mode_e'(bus.mode_sel) : mode_q;
    assign addr_last = (mode_q == Mode1) ? ADDR_LAST1 : ADDR_LAST0;

    timing_axis #(
        .Width  (H_W),
        .SyncPol(H_SYNC_POL),
        .Timing0(H_T0),
        .Timing1(H_T1)
    ) u_h_axis (
        .clk_i      (clk),
        .rst_i      (rst),
        .advance_i  (bus.pix_en),
        .mode_cur_i (mode_q),
        .mode_nxt_i (mode_d),
        .cnt_o      (bus.x),
        .wrap_o     (h_wrap),
        .blank_o    (bus.h_blank),
        .blank_nxt_o(h_blank_nxt),
        .sync_o     (bus.h_sync)
    );

    timing_axis #(
        .Width  (V_W),
        .SyncPol(V_SYNC_POL),
        .Timing0(V_T0),
        .Timing1(V_T1)
    ) u_v_axis (
        .clk_i      (clk),
        .rst_i      (rst),
        .advance_i  (h_wrap),
        .mode_cur_i (mode_q),
        .mode_nxt_i (mode_d),
        .cnt_o      (bus.y),
        .wrap_o     (v_wrap),
        .blank_o    (bus.v_blank),
        .blank_nxt_o(v_blank_nxt),
        .sync_o     (bus.v_sync)
    );

    always_comb begin
        addr_d        = addr_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (bus.pix_en) begin
            line_start_d  = h_wrap;
            frame_start_d = v_wrap;
            de_d          = !h_blank_nxt && !v_blank_nxt;
            // Saturate at the last active pixel so the address never leaves the frame buffer.
            if (v_wrap) begin
                addr_d = '0;
            end else if (de_q && addr_q != addr_last) begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= Mode0;
            addr_q        <= '0;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            addr_q        <= addr_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_ff @(posedge clk) begin
        assert (CFG_OK)
        else $fatal(1, "video_timing_gen: timing totals exceed counter or address width");
    end

    assign bus.mode_active = mode_q;
    assign bus.addr        = addr_q;
    assign bus.de          = de_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

endmodule
